// File: rtl/reg_writer_pkg.sv
// rtl/reg_writer_pkg.sv - shared types and constants for the reg_writer command path
// Contents:
//   state_t           controller FSM encoding (IDLE, ISSUE, BUSY)
//   REGNUM_*          register numbers walked by reg_writer
//   expected_last()   register a clean sequence ends on, by direction
package reg_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

    localparam int REGNUM_W = 5;
    localparam logic [REGNUM_W-1:0] REGNUM_START     = 5'd8;
    localparam logic [REGNUM_W-1:0] REGNUM_UP_LAST   = 5'd12;
    localparam logic [REGNUM_W-1:0] REGNUM_DOWN_LAST = 5'd4;

    function automatic logic [REGNUM_W-1:0] expected_last(input logic dir);
        return dir ? REGNUM_UP_LAST : REGNUM_DOWN_LAST;
    endfunction

endpackage

// File: rtl/reg_writer_ctrl_if.sv
// rtl/reg_writer_ctrl_if.sv - command, reg_writer and completion signals of reg_writer_ctrl
// Signals:
//   cmd_valid/cmd_ready/cmd_dir/cmd_tag   command offer (dir 1 = up, 0 = down)
//   go/direction                          to reg_writer
//   done/regnum                           from reg_writer
//   cmp_valid/cmp_tag/cmp_ok              completion pulse
// Modports: master = controller side, slave = environment side.
interface reg_writer_ctrl_if #(
    parameter int TAG_W = 4
);
    import reg_writer_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_dir;
    logic [TAG_W-1:0]    cmd_tag;
    logic                go;
    logic                direction;
    logic                done;
    logic [REGNUM_W-1:0] regnum;
    logic                cmp_valid;
    logic [TAG_W-1:0]    cmp_tag;
    logic                cmp_ok;

    modport master (
        input  cmd_valid, cmd_dir, cmd_tag, done, regnum,
        output cmd_ready, go, direction, cmp_valid, cmp_tag, cmp_ok
    );

    modport slave (
        output cmd_valid, cmd_dir, cmd_tag, done, regnum,
        input  cmd_ready, go, direction, cmp_valid, cmp_tag, cmp_ok
    );

endinterface

// File: rtl/reg_cmd_fifo.sv
// rtl/reg_cmd_fifo.sv - small synchronous FIFO holding queued commands
// Ports:
//   i_clk, i_rst   clock, synchronous active-high reset (empties the queue)
//   i_push, i_din  write one entry (ignored when full)
//   i_pop, o_dout  o_dout shows the head entry; i_pop discards it (ignored when empty)
//   o_full, o_empty occupancy flags
module reg_cmd_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    // One extra pointer bit separates the full and empty cases.
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/reg_writer_ctrl.sv
// rtl/reg_writer_ctrl.sv - command sequencer in front of the reg_writer FSM
// Queues direction commands, issues each as a one-cycle go with direction held,
// waits for done, checks the last register reached, reports one completion each.
// Ports:
//   i_clock        clock
//   i_reset        synchronous active-high reset; flushes queue, FSM to IDLE
//   bus (master)   command / reg_writer / completion signals
//   o_busy         FSM not IDLE or queue non-empty
//   o_err_timeout  sticky timeout flag
// Optional feature macro: REG_WRITER_CTRL_TIMEOUT_EN (BUSY timeout counter).
module reg_writer_ctrl
    import reg_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic               i_clock,
    input  logic               i_reset,
    reg_writer_ctrl_if.master  bus,
    output logic               o_busy,
    output logic               o_err_timeout
);
    state_t              r_state;
    state_t              w_next_state;
    logic                r_dir;
    logic [TAG_W-1:0]    r_tag;
    logic [REGNUM_W-1:0] r_last_reg;
    logic                r_cmp_valid;
    logic [TAG_W-1:0]    r_cmp_tag;
    logic                r_cmp_ok;

    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [TAG_W:0]      w_fifo_dout;
    logic                w_complete;
    logic                w_timeout;
    logic                w_timeout_hit;

    // Ready is held low during reset so nothing is queued into a flushing FIFO.
    assign bus.cmd_ready = !w_full && !i_reset;
    assign w_push        = bus.cmd_valid && bus.cmd_ready;
    assign o_busy        = (r_state != ST_IDLE) || !w_empty;
    assign bus.cmp_valid = r_cmp_valid;
    assign bus.cmp_tag   = r_cmp_tag;
    assign bus.cmp_ok    = r_cmp_ok;

    reg_cmd_fifo #(
        .WIDTH (TAG_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clock),
        .i_rst   (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   ({bus.cmd_dir, bus.cmd_tag}),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // done is still high from the previous run while in ISSUE, so it is only
    // looked at in BUSY. done takes priority over a coincident timeout.
    always_comb begin
        w_next_state  = r_state;
        w_pop         = 1'b0;
        w_complete    = 1'b0;
        w_timeout     = 1'b0;
        bus.go        = 1'b0;
        bus.direction = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                bus.go        = 1'b1;
                bus.direction = r_dir;
                w_next_state  = ST_BUSY;
            end
            ST_BUSY: begin
                // reg_writer samples direction during its run, so keep it steady.
                bus.direction = r_dir;
                if (bus.done) begin
                    w_complete   = 1'b1;
                    w_next_state = ST_IDLE;
                end else if (w_timeout_hit) begin
                    w_complete   = 1'b1;
                    w_timeout    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_dir       <= 1'b0;
            r_tag       <= '0;
            r_last_reg  <= '0;
            r_cmp_valid <= 1'b0;
            r_cmp_tag   <= '0;
            r_cmp_ok    <= 1'b0;
        end else begin
            r_cmp_valid <= w_complete;
            if (w_pop) begin
                r_dir      <= w_fifo_dout[TAG_W];
                r_tag      <= w_fifo_dout[TAG_W-1:0];
                r_last_reg <= '0;
            end else if (r_state == ST_BUSY && bus.regnum != '0) begin
                r_last_reg <= bus.regnum;
            end
            if (w_complete) begin
                r_cmp_tag <= r_tag;
                r_cmp_ok  <= !w_timeout && (r_last_reg == expected_last(r_dir));
            end
        end
    end

`ifdef REG_WRITER_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_err_timeout;

    // Counter holds the number of BUSY cycles already spent, so the limit is
    // hit on the TIMEOUT-th BUSY cycle.
    assign w_timeout_hit = (r_to_cnt == TO_W'(TIMEOUT - 1));
    assign o_err_timeout = r_err_timeout;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_to_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            if (r_state == ST_BUSY) r_to_cnt <= r_to_cnt + 1'b1;
            else                    r_to_cnt <= '0;
            if (w_timeout) r_err_timeout <= 1'b1;
        end
    end
`else
    assign w_timeout_hit = 1'b0;
    assign o_err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_reg_writer_ctrl.sv
// tb/tb_reg_writer_ctrl.sv - self-checking bench for reg_writer_ctrl
module tb_reg_writer_ctrl;
    import reg_writer_pkg::*;

    localparam int TAG_W   = 4;
    localparam int GO_LAT  = 2;
    localparam int CMP_LAT = 9;
    localparam int GO_GAP  = 8;
    localparam int TO_LAT  = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic err_timeout;

    always #5 clk = ~clk;

    reg_writer_ctrl_if #(.TAG_W(TAG_W)) bus ();

    reg_writer_ctrl #(
        .FIFO_DEPTH (4),
        .TAG_W      (TAG_W),
        .TIMEOUT    (15)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .bus           (bus),
        .o_busy        (busy),
        .o_err_timeout (err_timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic rst_at_edge = 1'b1;

    always @(posedge clk) begin
        cyc = cyc + 1;
        rst_at_edge = rst;
    end

    // reg_writer model: 0 = normal, 1 = up run stops at 11, 2 = never finishes
    int   stub_mode = 0;
    logic s_run = 1'b0;
    logic s_hang = 1'b0;
    int   s_cnt = 0;
    int   s_len = 5;

    always @(posedge clk) begin
        if (rst) begin
            s_run      <= 1'b0;
            s_cnt      <= 0;
            bus.done   <= 1'b1;
            bus.regnum <= '0;
        end else if (!s_run) begin
            if (bus.go) begin
                s_run      <= 1'b1;
                s_cnt      <= 1;
                s_len      <= (stub_mode == 1) ? 4 : 5;
                s_hang     <= (stub_mode == 2);
                bus.done   <= 1'b0;
                bus.regnum <= REGNUM_START;
            end
        end else if (s_cnt == s_len) begin
            if (!s_hang) begin
                s_run      <= 1'b0;
                bus.done   <= 1'b1;
                bus.regnum <= '0;
            end
        end else begin
            bus.regnum <= bus.direction ? 5'(REGNUM_START + 5'(s_cnt)) : 5'(REGNUM_START - 5'(s_cnt));
            s_cnt      <= s_cnt + 1;
        end
    end

    // Monitor: times are recorded as the clock edge that samples the value.
    int               go_q[$];
    logic             go_dir_q[$];
    int               cmp_edge_q[$];
    logic [TAG_W-1:0] cmp_tag_q[$];
    logic             cmp_ok_q[$];
    int               dir_bad = 0;
    int               go_long = 0;
    logic             in_cmd = 1'b0;
    logic             cur_dir = 1'b0;
    logic             go_prev = 1'b0;

    always @(negedge clk) begin
        #1;
        if (rst_at_edge) in_cmd = 1'b0;
        if (bus.cmp_valid) begin
            in_cmd = 1'b0;
            cmp_edge_q.push_back(cyc + 1);
            cmp_tag_q.push_back(bus.cmp_tag);
            cmp_ok_q.push_back(bus.cmp_ok);
        end
        if (bus.go) begin
            go_q.push_back(cyc + 1);
            go_dir_q.push_back(bus.direction);
            cur_dir = bus.direction;
            in_cmd  = 1'b1;
            if (go_prev) go_long = go_long + 1;
        end else if (in_cmd && bus.direction != cur_dir) begin
            dir_bad = dir_bad + 1;
        end
        go_prev = bus.go;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic dir, input logic [TAG_W-1:0] tag, output int edge_o);
        int budget = 50;
        while (!bus.cmd_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check("cmd_ready_wait", 32'(bus.cmd_ready), 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_dir   = dir;
        bus.cmd_tag   = tag;
        edge_o        = cyc + 1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_cmps(input int n, input int budget);
        int b = budget;
        while (cmp_edge_q.size() < n && b > 0) begin
            @(negedge clk);
            #2;
            b--;
        end
        if (cmp_edge_q.size() < n) check("cmp_wait", 32'(cmp_edge_q.size()), 32'(n));
    endtask

    typedef struct {
        logic             dir;
        logic [TAG_W-1:0] tag;
        int               mode;
        logic             exp_ok;
        int               exp_lat;
    } vec_t;

    vec_t vecs[4];
    logic             bb_dir[5];
    logic [TAG_W-1:0] bb_tag[5];
    int g0, c0, d0, pe, pe0, tmp;

    initial begin
        vecs[0] = '{1'b1, 4'd3,  0, 1'b1, CMP_LAT};
        vecs[1] = '{1'b0, 4'd5,  0, 1'b1, CMP_LAT};
        vecs[2] = '{1'b1, 4'd12, 1, 1'b0, CMP_LAT - 1};
        vecs[3] = '{1'b0, 4'd15, 0, 1'b1, CMP_LAT};
        bb_dir  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        bb_tag  = '{4'd1, 4'd2, 4'd7, 4'd9, 4'd14};

        bus.cmd_valid = 1'b0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_tag   = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("rst_cmd_ready", 32'(bus.cmd_ready), 0);
        check("rst_go", 32'(bus.go), 0);
        check("rst_direction", 32'(bus.direction), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_cmp_valid", 32'(bus.cmp_valid), 0);
        check("rst_err_timeout", 32'(err_timeout), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check("post_rst_cmd_ready", 32'(bus.cmd_ready), 1);

        // Single commands from the vector table
        for (int i = 0; i < 4; i++) begin
            stub_mode = vecs[i].mode;
            g0 = go_q.size();
            c0 = cmp_edge_q.size();
            d0 = dir_bad;
            push_cmd(vecs[i].dir, vecs[i].tag, pe);
            wait_cmps(c0 + 1, 40);
            #2;
            check("vec_go_count", 32'(go_q.size() - g0), 1);
            if (go_q.size() > g0) begin
                check("vec_go_lat", 32'(go_q[g0] - pe), GO_LAT);
                check("vec_go_dir", 32'(go_dir_q[g0]), 32'(vecs[i].dir));
            end
            if (cmp_edge_q.size() > c0) begin
                check("vec_cmp_lat", 32'(cmp_edge_q[c0] - pe), 32'(vecs[i].exp_lat));
                check("vec_cmp_tag", 32'(cmp_tag_q[c0]), 32'(vecs[i].tag));
                check("vec_cmp_ok", 32'(cmp_ok_q[c0]), 32'(vecs[i].exp_ok));
            end
            check("vec_dir_held", 32'(dir_bad - d0), 0);
            check("vec_err_timeout", 32'(err_timeout), 0);
            check("vec_busy_after", 32'(busy), 0);
            repeat (2) @(negedge clk);
        end

        // Back-to-back: one command in flight plus four queued fills the FIFO
        stub_mode = 0;
        g0 = go_q.size();
        c0 = cmp_edge_q.size();
        d0 = dir_bad;
        push_cmd(bb_dir[0], bb_tag[0], pe0);
        for (int k = 1; k < 5; k++) push_cmd(bb_dir[k], bb_tag[k], tmp);
        #1;
        check("bb_ready_full", 32'(bus.cmd_ready), 0);
        check("bb_busy", 32'(busy), 1);
        wait_cmps(c0 + 5, 80);
        #2;
        check("bb_go_count", 32'(go_q.size() - g0), 5);
        for (int k = 0; k < 5; k++) begin
            if (go_q.size() > g0 + k) begin
                check("bb_go_edge", 32'(go_q[g0 + k] - pe0), 32'(GO_LAT + GO_GAP * k));
                check("bb_go_dir", 32'(go_dir_q[g0 + k]), 32'(bb_dir[k]));
            end
            if (cmp_edge_q.size() > c0 + k) begin
                check("bb_cmp_edge", 32'(cmp_edge_q[c0 + k] - pe0), 32'(CMP_LAT + GO_GAP * k));
                check("bb_cmp_tag", 32'(cmp_tag_q[c0 + k]), 32'(bb_tag[k]));
                check("bb_cmp_ok", 32'(cmp_ok_q[c0 + k]), 1);
            end
        end
        check("bb_dir_held", 32'(dir_bad - d0), 0);
        check("bb_ready_after", 32'(bus.cmd_ready), 1);
        repeat (2) @(negedge clk);

        // Reset in cycle t+5 of a run, with two more commands queued
        g0 = go_q.size();
        c0 = cmp_edge_q.size();
        push_cmd(1'b1, 4'd6, pe);
        push_cmd(1'b0, 4'd8, tmp);
        push_cmd(1'b1, 4'd10, tmp);
        while (cyc + 1 < pe + 5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #2;
        check("mid_rst_go", 32'(bus.go), 0);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_cmp_valid", 32'(bus.cmp_valid), 0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        #2;
        check("mid_rst_no_cmp", 32'(cmp_edge_q.size() - c0), 0);
        check("mid_rst_queue_lost", 32'(go_q.size() - g0), 1);
        check("mid_rst_busy_after", 32'(busy), 0);
        g0 = go_q.size();
        d0 = dir_bad;
        push_cmd(1'b0, 4'd11, pe);
        wait_cmps(c0 + 1, 40);
        #2;
        if (go_q.size() > g0) check("after_rst_go_lat", 32'(go_q[g0] - pe), GO_LAT);
        if (cmp_edge_q.size() > c0) begin
            check("after_rst_cmp_lat", 32'(cmp_edge_q[c0] - pe), CMP_LAT);
            check("after_rst_tag", 32'(cmp_tag_q[c0]), 11);
            check("after_rst_ok", 32'(cmp_ok_q[c0]), 1);
        end
        check("after_rst_dir_held", 32'(dir_bad - d0), 0);
        repeat (2) @(negedge clk);

`ifdef REG_WRITER_CTRL_TIMEOUT_EN
        // Stub never raises done
        stub_mode = 2;
        g0 = go_q.size();
        c0 = cmp_edge_q.size();
        push_cmd(1'b1, 4'd4, pe);
        wait_cmps(c0 + 1, 40);
        #2;
        if (cmp_edge_q.size() > c0) begin
            check("to_cmp_lat", 32'(cmp_edge_q[c0] - pe), TO_LAT);
            check("to_cmp_tag", 32'(cmp_tag_q[c0]), 4);
            check("to_cmp_ok", 32'(cmp_ok_q[c0]), 0);
        end
        check("to_err_set", 32'(err_timeout), 1);
        push_cmd(1'b0, 4'd13, pe);
        wait_cmps(c0 + 2, 40);
        #2;
        check("to_next_go_count", 32'(go_q.size() - g0), 2);
        if (go_q.size() > g0 + 1) check("to_next_go_lat", 32'(go_q[g0 + 1] - pe), GO_LAT);
        if (cmp_edge_q.size() > c0 + 1) check("to_next_tag", 32'(cmp_tag_q[c0 + 1]), 13);
        check("to_err_sticky", 32'(err_timeout), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        #2;
        check("to_err_cleared", 32'(err_timeout), 0);
        stub_mode = 0;
`endif

        check("go_single_cycle", 32'(go_long), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
